// File: rtl/joypad_i2c_reader.sv
// Polls an I2C joypad expander: reads one byte from DEV_ADDR, then idles for POLL_GAP
// quarter-phases. The device reports active-low buttons, so the published state is inverted.
module joypad_i2c_reader #(
    parameter int unsigned CLK_DIV  = 50,
    parameter logic [6:0]  DEV_ADDR = 7'h20,
    parameter int unsigned POLL_GAP = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       joypad_scl_out,
    output logic       joypad_sda_out,
    input  logic       joypad_sda_in,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       nack_err
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(POLL_GAP - 1);
    localparam logic [7:0] AddrByte = {DEV_ADDR, 1'b1};

    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StAddrAck, StRead, StMack, StStop, StWait
    } state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [GapW-1:0] gap_q;
    logic [1:0]      ph_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            ack_ok_q;
    logic            sda_s1_q, sda_s2_q;
    logic            scl_q, sda_q;
    logic [7:0]      buttons_q;
    logic            valid_q, nack_q;
    logic            tick;

    assign tick           = (div_q == DivLast);
    assign joypad_scl_out = scl_q;
    assign joypad_sda_out = sda_q;
    assign buttons        = buttons_q;
    assign buttons_valid  = valid_q;
    assign nack_err       = nack_q;

    // Free-running quarter-phase divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Two-flop synchronizer for the incoming SDA level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            sda_s1_q <= joypad_sda_in;
            sda_s2_q <= sda_s1_q;
        end
    end

    // Bus sequencer; bit states use p0 set SDA, p1 raise SCL, p2 sample, p3 drop SCL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gap_q     <= '0;
            ph_q      <= 2'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            ack_ok_q  <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            buttons_q <= 8'h00;
            valid_q   <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        scl_q    <= 1'b1;
                        sda_q    <= 1'b1;
                        ack_ok_q <= 1'b0;
                        ph_q     <= 2'd0;
                        state_q  <= StStart;
                    end
                    StStart: begin
                        if (ph_q == 2'd0) begin
                            sda_q <= 1'b0;
                            ph_q  <= 2'd1;
                        end else begin
                            scl_q   <= 1'b0;
                            ph_q    <= 2'd0;
                            bit_q   <= 3'd0;
                            state_q <= StAddr;
                        end
                    end
                    StAddr, StAddrAck, StRead, StMack: begin
                        ph_q <= ph_q + 2'd1;
                        if (ph_q == 2'd0) begin
                            sda_q <= (state_q == StAddr) ? AddrByte[3'd7 - bit_q] : 1'b1;
                        end
                        if (ph_q == 2'd1) begin
                            scl_q <= 1'b1;
                        end
                        if (ph_q == 2'd2) begin
                            if (state_q == StAddrAck) begin
                                ack_ok_q <= ~sda_s2_q;
                            end
                            if (state_q == StRead) begin
                                shift_q <= {shift_q[6:0], sda_s2_q};
                            end
                        end
                        if (ph_q == 2'd3) begin
                            scl_q <= 1'b0;
                            bit_q <= bit_q + 3'd1;
                            if (state_q == StAddr && bit_q == 3'd7) begin
                                state_q <= StAddrAck;
                            end else if (state_q == StAddrAck) begin
                                bit_q <= 3'd0;
                                if (ack_ok_q) begin
                                    state_q <= StRead;
                                end else begin
                                    nack_q  <= 1'b1;
                                    state_q <= StStop;
                                end
                            end else if (state_q == StRead && bit_q == 3'd7) begin
                                state_q <= StMack;
                            end else if (state_q == StMack) begin
                                state_q <= StStop;
                            end
                        end
                    end
                    StStop: begin
                        ph_q <= ph_q + 2'd1;
                        if (ph_q == 2'd0) begin
                            sda_q <= 1'b0;
                        end else if (ph_q == 2'd1) begin
                            scl_q <= 1'b1;
                        end else begin
                            sda_q   <= 1'b1;
                            ph_q    <= 2'd0;
                            gap_q   <= '0;
                            state_q <= StWait;
                            // ack_ok_q is only set once the address was acknowledged.
                            if (ack_ok_q) begin
                                buttons_q <= ~shift_q;
                                valid_q   <= 1'b1;
                            end
                        end
                    end
                    StWait: begin
                        if (gap_q == GapLast) begin
                            gap_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joypad_i2c_reader.sv
// Bench for joypad_i2c_reader with a behavioural I2C slave and a button scoreboard.
module tb_joypad_i2c_reader;

    localparam int unsigned ClkDiv  = 4;
    localparam int unsigned PollGap = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       joypad_scl_out, joypad_sda_out;
    logic       sda_line, scl_line;
    logic       slave_sda = 1'b1;
    logic [7:0] buttons;
    logic       buttons_valid, nack_err;

    int total = 0;
    int bad = 0;

    // Slave side state.
    logic [7:0] slave_q[$];
    logic [7:0] addr_seen = 8'h00;
    logic [7:0] cur_byte;
    int         rd_idx = 0;
    int         cur_idx = -1;
    int         slave_idx = -1;

    // Monitor state.
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         valid_cyc[$];
    int         valid_cnt = 0;
    int         cyc = 0;
    int         falls_high = 0;
    int         rises_high = 0;
    int         hi_len = 0;
    int         bit_hi = 0;
    int         short_hi = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    assign sda_line = joypad_sda_out & slave_sda;
    assign scl_line = joypad_scl_out;

    joypad_i2c_reader #(
        .CLK_DIV (ClkDiv),
        .DEV_ADDR(7'h20),
        .POLL_GAP(PollGap)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .joypad_scl_out(joypad_scl_out),
        .joypad_sda_out(joypad_sda_out),
        .joypad_sda_in (sda_line),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .nack_err      (nack_err)
    );

    always #5 clk = ~clk;

    // Bus and output monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_scl <= scl_line;
        prev_sda <= sda_line;
        if (rst_n) begin
            if (buttons_valid) begin
                valid_cnt <= valid_cnt + 1;
                obs_q.push_back(buttons);
                valid_cyc.push_back(cyc);
            end
            if (prev_scl && scl_line && prev_sda && !sda_line) falls_high <= falls_high + 1;
            if (prev_scl && scl_line && !prev_sda && sda_line) rises_high <= rises_high + 1;
            if (scl_line) begin
                hi_len <= hi_len + 1;
            end else begin
                if (prev_scl && hi_len == 2 * ClkDiv) bit_hi <= bit_hi + 1;
                if (prev_scl && hi_len < 2 * ClkDiv) short_hi <= short_hi + 1;
                hi_len <= 0;
            end
        end
    end

    // Behavioural slave: captures the address, ACKs when a byte is queued, returns it MSB first.
    initial begin
        forever begin
            @(negedge sda_line);
            if (scl_line === 1'b1 && rst_n) begin
                for (int i = 7; i >= 0; i--) begin
                    @(posedge scl_line);
                    addr_seen[i] = sda_line;
                end
                @(negedge scl_line);
                if (rd_idx < slave_q.size()) begin
                    cur_byte  = slave_q[rd_idx];
                    cur_idx   = rd_idx;
                    slave_sda = 1'b0;
                    @(negedge scl_line);
                    for (int i = 7; i >= 0; i--) begin
                        slave_idx = i;
                        slave_sda = cur_byte[i];
                        @(negedge scl_line);
                    end
                    slave_sda = 1'b1;
                    rd_idx++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            check(tag, obs_q.size(), 1);
        end else begin
            check(tag, obs_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        int n;
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_scl", joypad_scl_out, 1);
        check("rst_sda", joypad_sda_out, 1);
        check("rst_buttons", buttons, 8'h00);
        check("rst_valid", buttons_valid, 0);
        check("rst_nack", nack_err, 0);

        // Transaction 1: slave ACKs and returns 0xFE.
        slave_q.push_back(8'hFE);
        exp_q.push_back(8'h01);
        rst_n = 1'b1;
        n = 0;
        while (joypad_sda_out === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_start_clocks", n, 2 * ClkDiv);
        check("start_scl_high", joypad_scl_out, 1);
        n = 0;
        while (joypad_scl_out === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tick_interval", n, ClkDiv);

        for (int k = 0; k < 2000 && valid_cnt < 1; k++) @(negedge clk);
        check("tx1_valid_seen", valid_cnt, 1);
        sb_check("tx1_buttons");
        check("tx1_nack", nack_err, 0);
        check("tx1_addr", addr_seen, 8'h41);
        repeat (2) @(negedge clk);
        check("tx1_single_pulse", valid_cnt, 1);

        // Transactions 2 and 3: 0x00 then 0xFF.
        slave_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        slave_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        for (int k = 0; k < 2000 && valid_cnt < 2; k++) @(negedge clk);
        check("tx2_valid_seen", valid_cnt, 2);
        sb_check("tx2_buttons");
        for (int k = 0; k < 2000 && valid_cnt < 3; k++) @(negedge clk);
        check("tx3_valid_seen", valid_cnt, 3);
        sb_check("tx3_buttons");
        check("valid_gap", (valid_cyc.size() >= 3 &&
                            valid_cyc[2] - valid_cyc[1] >= int'(PollGap * ClkDiv)), 1);

        // Transaction 4: no byte queued, so nobody ACKs.
        for (int k = 0; k < 2000 && nack_err !== 1'b1; k++) @(negedge clk);
        check("tx4_nack", nack_err, 1);
        for (int k = 0; k < 2000 && rises_high < 4; k++) @(negedge clk);
        check("tx4_stop_seen", rises_high, 4);
        check("start_count", falls_high, 4);
        check("tx4_buttons_held", buttons, 8'h00);
        check("tx4_no_pulse", valid_cnt, 3);
        check("tx4_addr", addr_seen, 8'h41);
        check("scl_high_bits", bit_hi, 3 * 18 + 9);
        check("scl_short_high", short_hi, 0);

        // Transaction 5: reset during READ bit 4.
        slave_q.push_back(8'hA5);
        for (int k = 0; k < 3000 && !(cur_idx == 3 && slave_idx == 3); k++) @(negedge clk);
        check("tx5_reached_bit4", (cur_idx == 3 && slave_idx == 3), 1);
        for (int k = 0; k < 100 && joypad_scl_out !== 1'b1; k++) @(negedge clk);
        check("tx5_scl_high", joypad_scl_out, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scl", joypad_scl_out, 1);
        check("mid_rst_sda", joypad_sda_out, 1);
        check("mid_rst_buttons", buttons, 8'h00);
        check("mid_rst_nack", nack_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
